// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - program sequencer: PC, jumps, return-address stack, fetch handshake
// Optional stack over/underflow trapping into ERR: define CPU_SEQ_STACK_CHECK_EN.
module cpu_seq_ctrl #(
  parameter int AWIDTH      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int SPW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [AWIDTH-1:0] IMEM_ADDR,
  output logic              IMEM_REQ,
  input  logic              IMEM_VALID,
  input  logic              STALL,
  input  logic [2:0]        JMP_MODE,
  input  logic [AWIDTH-1:0] JMP_ADDR,
  input  logic              ZERO,
  output logic              INSTR_EN,
  output logic [AWIDTH-1:0] PC_OUT,
  output logic [SPW-1:0]    SP_OUT,
  output logic              HALTED,
  output logic              STACK_ERR
);

  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] M_ABS  = 3'b001;
  localparam logic [2:0] M_REL  = 3'b010;
  localparam logic [2:0] M_JZ   = 3'b011;
  localparam logic [2:0] M_CALL = 3'b100;
  localparam logic [2:0] M_RET  = 3'b101;
  localparam logic [2:0] M_HALT = 3'b110;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AWIDTH-1:0] r_pc;
  logic [AWIDTH-1:0] w_pc_nxt;
  logic [AWIDTH-1:0] w_pc_inc;
  logic [SPW-1:0]    r_sp;
  logic [SPW-1:0]    w_sp_nxt;
  logic [AWIDTH-1:0] r_stack [STACK_DEPTH];
  logic              w_run;
  logic              w_fetch;
  logic              w_full;
  logic              w_empty;
  logic              w_commit;
  logic              w_push;
  logic [IW-1:0]     w_top_idx;
  logic [IW-1:0]     w_push_idx;

  assign w_pc_inc   = r_pc + AWIDTH'(1);
  assign w_full     = (r_sp == SPW'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_top_idx  = IW'(r_sp - SPW'(1));
  // A push on a full stack lands on the top entry instead of running off the end.
  assign w_push_idx = w_full ? IW'(STACK_DEPTH - 1) : IW'(r_sp);

  assign w_run   = (r_state == S_RUN) & RST;
  assign w_fetch = w_run & IMEM_VALID & ~STALL;

`ifdef CPU_SEQ_STACK_CHECK_EN
  logic w_ovf;
  logic w_unf;
  assign w_ovf    = (JMP_MODE == M_CALL) & w_full;
  assign w_unf    = (JMP_MODE == M_RET) & w_empty;
  assign w_commit = w_fetch & ~(w_ovf | w_unf);
`else
  assign w_commit = w_fetch;
`endif

  always_comb begin
    w_pc_nxt    = r_pc;
    w_sp_nxt    = r_sp;
    w_state_nxt = r_state;
    w_push      = 1'b0;
    if (w_commit) begin
      case (JMP_MODE)
        M_ABS:  w_pc_nxt = JMP_ADDR;
        M_REL:  w_pc_nxt = r_pc + JMP_ADDR;
        M_JZ:   w_pc_nxt = ZERO ? JMP_ADDR : w_pc_inc;
        M_CALL: begin
          w_pc_nxt = JMP_ADDR;
          w_push   = 1'b1;
          if (!w_full) w_sp_nxt = r_sp + SPW'(1);
        end
        M_RET: begin
          if (w_empty) begin
            w_pc_nxt = '0;
          end else begin
            w_pc_nxt = r_stack[w_top_idx];
            w_sp_nxt = r_sp - SPW'(1);
          end
        end
        M_HALT: w_state_nxt = S_HALT;
        default: w_pc_nxt = w_pc_inc;
      endcase
    end
`ifdef CPU_SEQ_STACK_CHECK_EN
    if (w_fetch & (w_ovf | w_unf)) w_state_nxt = S_ERR;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_RUN;
      r_pc    <= '0;
      r_sp    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_sp    <= w_sp_nxt;
    end
  end

  // Stack contents are left unreset; only SP defines which entries are meaningful.
  always_ff @(posedge CLK) begin
    if (RST && w_push) r_stack[w_push_idx] <= w_pc_inc;
  end

  assign IMEM_ADDR = r_pc;
  assign IMEM_REQ  = w_run;
  assign INSTR_EN  = w_commit;
  assign PC_OUT    = r_pc;
  assign SP_OUT    = r_sp;
  assign HALTED    = (r_state == S_HALT);
`ifdef CPU_SEQ_STACK_CHECK_EN
  assign STACK_ERR = (r_state == S_ERR);
`else
  assign STACK_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb/tb_cpu_seq_ctrl.sv - scoreboard bench for cpu_seq_ctrl (AWIDTH=8, STACK_DEPTH=4)
// Honours CPU_SEQ_STACK_CHECK_EN in its reference model.
module tb_cpu_seq_ctrl;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] IMEM_ADDR;
  logic       IMEM_REQ;
  logic       IMEM_VALID = 1'b0;
  logic       STALL = 1'b0;
  logic [2:0] JMP_MODE = 3'b000;
  logic [7:0] JMP_ADDR = 8'h00;
  logic       ZERO = 1'b0;
  logic       INSTR_EN;
  logic [7:0] PC_OUT;
  logic [2:0] SP_OUT;
  logic       HALTED;
  logic       STACK_ERR;

  cpu_seq_ctrl #(.AWIDTH(8), .STACK_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .IMEM_ADDR(IMEM_ADDR), .IMEM_REQ(IMEM_REQ),
    .IMEM_VALID(IMEM_VALID), .STALL(STALL), .JMP_MODE(JMP_MODE), .JMP_ADDR(JMP_ADDR),
    .ZERO(ZERO), .INSTR_EN(INSTR_EN), .PC_OUT(PC_OUT), .SP_OUT(SP_OUT),
    .HALTED(HALTED), .STACK_ERR(STACK_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] pc;
    logic [2:0] sp;
    logic       halted;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] m_pc = 8'h00;
  int         m_sp = 0;
  int         m_state = 0;
  logic [7:0] m_stk [4];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [2:0] mode, input logic [7:0] addr, input logic z,
                     input logic v, input logic s, input logic rst);
    bit         en;
    bit         trap;
    logic [7:0] inc;
    exp_t       e;
    JMP_MODE = mode; JMP_ADDR = addr; ZERO = z; IMEM_VALID = v; STALL = s; RST = rst;
    #1;
    en   = rst && (m_state == 0) && v && !s;
    trap = 1'b0;
`ifdef CPU_SEQ_STACK_CHECK_EN
    if (en && ((mode == 3'd4 && m_sp == 4) || (mode == 3'd5 && m_sp == 0))) begin
      en   = 1'b0;
      trap = 1'b1;
    end
`endif
    check_val("instr_en", INSTR_EN, en);
    check_val("imem_req", IMEM_REQ, rst && (m_state == 0));
    if (rst) check_val("imem_addr", IMEM_ADDR, m_pc);
    inc = m_pc + 8'd1;
    if (!rst) begin
      m_pc = 8'h00; m_sp = 0; m_state = 0;
    end else begin
      if (trap) m_state = 2;
      if (en) begin
        case (mode)
          3'd1: m_pc = addr;
          3'd2: m_pc = m_pc + addr;
          3'd3: m_pc = z ? addr : inc;
          3'd4: begin
            if (m_sp == 4) m_stk[3] = inc;
            else begin m_stk[m_sp] = inc; m_sp++; end
            m_pc = addr;
          end
          3'd5: begin
            if (m_sp == 0) m_pc = 8'h00;
            else begin m_sp--; m_pc = m_stk[m_sp]; end
          end
          3'd6: m_state = 1;
          default: m_pc = inc;
        endcase
      end
    end
    e.pc = m_pc; e.sp = 3'(m_sp); e.halted = (m_state == 1); e.err = (m_state == 2);
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check_val("pc", PC_OUT, e.pc);
    check_val("sp", SP_OUT, e.sp);
    check_val("halted", HALTED, e.halted);
    check_val("stack_err", STACK_ERR, e.err);
  endtask

  task automatic run(input logic [2:0] mode, input logic [7:0] addr);
    cyc(mode, addr, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    cyc(3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    do_reset();
    check_val("rst_pc", PC_OUT, 8'h00);
    check_val("rst_sp", SP_OUT, 3'd0);

    for (int i = 0; i < 260; i++) run(3'd0, 8'h00);
    check_val("wrap_pc", PC_OUT, 8'h04);
    run(3'd7, 8'h00);
    check_val("mode7_pc", PC_OUT, 8'h05);

    run(3'd1, 8'h10);
    run(3'd2, 8'hFC);
    check_val("rel_pc", PC_OUT, 8'h0C);
    cyc(3'd3, 8'h40, 1'b0, 1'b1, 1'b0, 1'b1);
    check_val("jz_nt_pc", PC_OUT, 8'h0D);
    run(3'd1, 8'h0C);
    cyc(3'd3, 8'h40, 1'b1, 1'b1, 1'b0, 1'b1);
    check_val("jz_t_pc", PC_OUT, 8'h40);

    run(3'd1, 8'h05);
    run(3'd4, 8'h20);
    check_val("call1_sp", SP_OUT, 3'd1);
    run(3'd0, 8'h00);
    run(3'd4, 8'h30);
    check_val("call2_sp", SP_OUT, 3'd2);
    run(3'd0, 8'h00);
    run(3'd0, 8'h00);
    run(3'd4, 8'h50);
    check_val("call3_sp", SP_OUT, 3'd3);
    run(3'd5, 8'h00);
    check_val("ret1_pc", PC_OUT, 8'h33);
    run(3'd5, 8'h00);
    check_val("ret2_pc", PC_OUT, 8'h22);
    run(3'd5, 8'h00);
    check_val("ret3_pc", PC_OUT, 8'h06);
    check_val("ret3_sp", SP_OUT, 3'd0);

    run(3'd4, 8'h60);
    run(3'd4, 8'h70);
    run(3'd4, 8'h80);
    run(3'd4, 8'h90);
    check_val("full_sp", SP_OUT, 3'd4);
    run(3'd4, 8'hA0);
`ifdef CPU_SEQ_STACK_CHECK_EN
    check_val("ovf_err", STACK_ERR, 1'b1);
    check_val("ovf_pc", PC_OUT, 8'h90);
    run(3'd0, 8'h00);
    check_val("err_frozen_pc", PC_OUT, 8'h90);
    do_reset();
    run(3'd5, 8'h00);
    check_val("unf_err", STACK_ERR, 1'b1);
    check_val("unf_pc", PC_OUT, 8'h00);
`else
    check_val("ovf_pc", PC_OUT, 8'hA0);
    check_val("ovf_sp", SP_OUT, 3'd4);
    run(3'd5, 8'h00);
    check_val("ovf_ret_pc", PC_OUT, 8'h91);
    run(3'd5, 8'h00);
    check_val("ovf_ret2_pc", PC_OUT, 8'h71);
    run(3'd5, 8'h00);
    run(3'd5, 8'h00);
    check_val("drain_sp", SP_OUT, 3'd0);
    run(3'd0, 8'h00);
    run(3'd5, 8'h00);
    check_val("unf_pc", PC_OUT, 8'h00);
    check_val("unf_sp", SP_OUT, 3'd0);
`endif

    do_reset();
    run(3'd0, 8'h00);
    run(3'd0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(3'd1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("novalid_pc", PC_OUT, 8'h02);
    for (int i = 0; i < 2; i++) cyc(3'd1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(3'd4, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("stall_pc", PC_OUT, 8'h02);
    check_val("stall_sp", SP_OUT, 3'd0);
    run(3'd1, 8'h07);
    run(3'd6, 8'h00);
    check_val("halt_flag", HALTED, 1'b1);
    check_val("halt_req", IMEM_REQ, 1'b0);
    check_val("halt_pc", PC_OUT, 8'h07);
    run(3'd1, 8'h33);
    run(3'd4, 8'h44);
    check_val("halt_frozen_pc", PC_OUT, 8'h07);
    do_reset();
    check_val("halt_rst_pc", PC_OUT, 8'h00);
    check_val("halt_rst_flag", HALTED, 1'b0);

    run(3'd0, 8'h00);
    run(3'd0, 8'h00);
    cyc(3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    check_val("stall_rst_pc", PC_OUT, 8'h00);
    run(3'd0, 8'h00);
    check_val("post_rst_pc", PC_OUT, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Program sequencer for the one-cycle CPU. It is the parametrised successor of the PC / jump / link-register path in the CPU control unit. It replaces the single link register with a return-address stack of configurable depth and adds a fetch handshake, so instruction memory may take several cycles. It adds a relative jump, a zero-conditional jump and a halt state. It sits between the instruction decoder, which supplies the jump controls, and the instruction memory, which it addresses.

## Interface
Parameters:
- AWIDTH, 8, program address width.
- STACK_DEPTH, 4, return-stack entries (>=1).
- SPW, $clog2(STACK_DEPTH+1), stack-pointer width (derived; do not override).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-low reset.
- IMEM_ADDR  out  AWIDTH  fetch address, combinationally equal to PC.
- IMEM_REQ  out  1  fetch request; 1 only in RUN.
- IMEM_VALID  in  1  instruction at IMEM_ADDR is present and the decoder outputs are valid.
- STALL  in  1  datapath hold; blocks commit.
- JMP_MODE  in  3  000 seq, 001 abs, 010 rel, 011 jz (abs if ZERO), 100 call, 101 ret, 110 halt, 111 treated as seq.
- JMP_ADDR  in  AWIDTH  absolute target (abs/jz/call) or two's-complement offset (rel).
- ZERO  in  1  accumulator zero flag, sampled in the commit cycle.
- INSTR_EN  out  1  current instruction commits this cycle.
- PC_OUT  out  AWIDTH  current PC.
- SP_OUT  out  SPW  number of valid stack entries.
- HALTED  out  1  state is HALT.
- STACK_ERR  out  1  sticky stack fault.

## Operation
- States: RUN, HALT, ERR. Reset enters RUN.
- Commit condition: commit = RUN & IMEM_VALID & ~STALL & RST. INSTR_EN = commit. There is no state change without commit, except reset.
- On commit, next PC is selected by JMP_MODE:
  - seq / 111: PC+1.
  - abs: JMP_ADDR.
  - rel: PC + JMP_ADDR, with JMP_ADDR treated as signed.
  - jz: JMP_ADDR if ZERO, else PC+1.
  - call: JMP_ADDR; push PC+1; SP+1.
  - ret: top of stack; SP-1.
  - halt: PC held; go to HALT.
- Arithmetic: all PC arithmetic is modulo 2^AWIDTH. PC+1 at all-ones wraps to 0. A rel result wraps silently.
- Stack is LIFO. The entry at index SP-1 is top. A push writes index SP.
- Call with SP==STACK_DEPTH: overflow. Ret with SP==0: underflow. Handling is per Configuration.
- HALT: IMEM_REQ=0, INSTR_EN=0, PC/SP frozen. Exit only by reset.
- ERR: same freeze as HALT; HALTED=0, STACK_ERR=1.
- STALL or !IMEM_VALID in RUN: PC, SP, stack and state all hold. IMEM_ADDR stays stable so the memory can complete.

## Timing
- Reset values (RST=0 at an edge): PC=0, SP=0, state RUN, HALTED=0, STACK_ERR=0. Stack contents are don't-care.
- While RST=0: INSTR_EN=0 and IMEM_REQ=0, combinationally.
- Latency: a commit at edge N means PC_OUT / IMEM_ADDR show the new value after edge N. A zero-wait memory therefore gives one instruction per cycle.
- The first fetch after reset release is address 0, with IMEM_REQ=1 in the same cycle RST goes high.
- HALTED and STACK_ERR assert the cycle after the committing edge.
- Reset mid-stall or mid-halt: reset wins and all state is reinitialised.
- IMEM_VALID may drop while STALL=1. Commit requires both conditions in the same cycle.

## Configuration
- Macro CPU_SEQ_STACK_CHECK_EN.
- Defined:
  - Overflow or underflow does not commit the call/ret: PC and SP are unchanged and INSTR_EN=0 that cycle.
  - The state goes to ERR and STACK_ERR=1.
- Undefined:
  - No ERR state; STACK_ERR is tied 0.
  - Call on full: overwrites the top entry (index STACK_DEPTH-1), SP unchanged, jump taken.
  - Ret on empty: PC goes to 0, SP stays 0.

## Test plan
- Reset, IMEM_VALID=1, JMP_MODE=000 for 260 cycles (AWIDTH=8) -> PC 0..255, then wraps to 0; INSTR_EN=1 every cycle.
- At PC=0x10: rel, JMP_ADDR=0xFC -> PC=0x0C. At PC=0x0C: jz 0x40, ZERO=0 -> 0x0D; repeat with ZERO=1 -> 0x40.
- Nested calls at PCs 0x05, 0x21, 0x32 to 0x20, 0x30, 0x50 -> SP 1,2,3. Three rets -> PC 0x33, 0x22, 0x06; SP back to 0.
- Fill stack (4 calls), then a 5th call -> with CPU_SEQ_STACK_CHECK_EN: state ERR, STACK_ERR=1, PC held. Without the macro: jump taken, SP=4, top overwritten, and subsequent ret returns the 5th call's return address.
- IMEM_VALID low 3 cycles, then STALL high 2 cycles, then halt at PC=0x07 -> PC held at each stall cycle. HALTED=1 the cycle after the halt commit and IMEM_REQ=0. RST low one edge -> PC=0, HALTED=0.
